// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: waits for PLL lock, holds, then releases rst_out_n bit 0 first with a fixed stagger.
// Optional restart-cause reporting (cause_o, restart_cnt_o) is built when RESET_SEQ_CAUSE_EN is defined.
module reset_sequencer #(
    parameter int N_OUT          = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock_i,
    input  logic             sw_rst_i,
    output logic [N_OUT-1:0] rst_out_n,
    output logic             all_done_o,
    output logic [1:0]       state_o
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]       cause_o,
    output logic [7:0]       restart_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0]       LAST_IDX = 3'(N_OUT - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_END = CNT_W'(STAGGER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic                   lock_s;
    state_t                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [2:0]             idx_r, idx_nxt_s;
    logic [N_OUT-1:0]       rst_out_r, rst_out_nxt_s, release_mask_s;
    logic                   done_r, done_nxt_s;
    logic                   restart_s;

    assign lock_s    = lock_sync_r[SYNC_STAGES-1];
    assign restart_s = (state_r != ST_ASSERT) && (!lock_s || sw_rst_i);

    // Lock synchronizer chain for the asynchronous PLL indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_r <= '0;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], lock_i};
        end
    end

    // One-hot mask selecting the output released next
    always_comb begin
        release_mask_s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (i == int'(idx_r)) begin
                release_mask_s[i] = 1'b1;
            end else begin
                release_mask_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; a restart overrides everything outside ASSERT
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        idx_nxt_s     = idx_r;
        rst_out_nxt_s = rst_out_r;
        done_nxt_s    = done_r;
        if (restart_s) begin
            state_nxt_s   = ST_ASSERT;
            cnt_nxt_s     = '0;
            idx_nxt_s     = 3'd0;
            rst_out_nxt_s = '0;
            done_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (lock_s) begin
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_ASSERT;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    if (cnt_r == ((state_r == ST_HOLD) ? HOLD_END : STAG_END)) begin
                        rst_out_nxt_s = rst_out_r | release_mask_s;
                        cnt_nxt_s     = '0;
                        if (idx_r == LAST_IDX) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                            idx_nxt_s   = idx_r + 3'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s   = ST_ASSERT;
                    cnt_nxt_s     = '0;
                    idx_nxt_s     = 3'd0;
                    rst_out_nxt_s = '0;
                    done_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_ASSERT;
            cnt_r     <= '0;
            idx_r     <= 3'd0;
            rst_out_r <= '0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            rst_out_r <= rst_out_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign rst_out_n  = rst_out_r;
    assign all_done_o = done_r;
    assign state_o    = state_r;

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_r;
    logic [7:0] restart_cnt_r;

    // Restart cause capture; software request wins when it coincides with lock loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_r       <= 2'b00;
            restart_cnt_r <= 8'd0;
        end else if (restart_s) begin
            cause_r       <= sw_rst_i ? 2'b10 : 2'b01;
            restart_cnt_r <= (restart_cnt_r == 8'd255) ? 8'd255 : restart_cnt_r + 8'd1;
        end else begin
            cause_r       <= cause_r;
            restart_cnt_r <= restart_cnt_r;
        end
    end

    assign cause_o       = cause_r;
    assign restart_cnt_o = restart_cnt_r;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus an N_OUT=1, HOLD_CYCLES=1 instance.
// Cause/restart-count checks are compiled only when RESET_SEQ_CAUSE_EN is defined.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_i = 1'b1;
    logic       sw_rst_i = 1'b0;
    logic [3:0] rst_out_n;
    logic       all_done;
    logic [1:0] state;
    logic [0:0] rst1;
    logic       done1;
    logic [1:0] state1;
    int         checks = 0;
    int         passes = 0;
    logic [6:0] exp_v;
    logic [6:0] obs_v;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause, cause1;
    logic [7:0] rcnt, rcnt1;
`endif

    reset_sequencer dut (
        .clk(clk), .rst_n(rst_n), .lock_i(lock_i), .sw_rst_i(sw_rst_i),
        .rst_out_n(rst_out_n), .all_done_o(all_done), .state_o(state)
`ifdef RESET_SEQ_CAUSE_EN
        , .cause_o(cause), .restart_cnt_o(rcnt)
`endif
    );

    reset_sequencer #(.N_OUT(1), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .lock_i(lock_i), .sw_rst_i(sw_rst_i),
        .rst_out_n(rst1), .all_done_o(done1), .state_o(state1)
`ifdef RESET_SEQ_CAUSE_EN
        , .cause_o(cause1), .restart_cnt_o(rcnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_por();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] por_exp(input int e);
        logic [3:0] r;
        logic [1:0] s;
        r = (e >= 43) ? 4'b1111 : (e >= 35) ? 4'b0111 : (e >= 27) ? 4'b0011 : (e >= 19) ? 4'b0001 : 4'b0000;
        s = (e >= 43) ? 2'd3 : (e >= 19) ? 2'd2 : (e >= 3) ? 2'd1 : 2'd0;
        return {r, (e >= 43) ? 1'b1 : 1'b0, s};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; lock_i = 1'b1; sw_rst_i = 1'b0;
        #3;
        obs_v = {rst_out_n, all_done, state};
        checks++;
        if (obs_v !== 7'b0000_0_00) $display("FAIL reset_async: got %b expected %b", obs_v, 7'b0000_0_00);
        else passes++;
        repeat (3) tick();
        obs_v = {rst_out_n, all_done, state};
        checks++;
        if (obs_v !== 7'b0000_0_00) $display("FAIL reset_held: got %b expected %b", obs_v, 7'b0000_0_00);
        else passes++;
        checks++;
        if ({rst1, done1, state1} !== 4'b0_0_00) $display("FAIL reset_n1: got %b expected 0000", {rst1, done1, state1});
        else passes++;
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if ({cause, rcnt} !== 10'd0) $display("FAIL reset_cause: got %b expected 0", {cause, rcnt});
        else passes++;
`endif
    endtask

    task automatic test_power_on();
        logic [3:0] exp1;
        do_por();
        for (int e = 1; e <= 45; e++) begin
            tick();
            exp_v = por_exp(e);
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== exp_v) $display("FAIL power_on e%0d: got %b expected %b", e, obs_v, exp_v);
            else passes++;
            exp1 = (e >= 4) ? 4'b1_1_11 : (e == 3) ? 4'b0_0_01 : 4'b0_0_00;
            checks++;
            if ({rst1, done1, state1} !== exp1) $display("FAIL n1_hold1 e%0d: got %b expected %b", e, {rst1, done1, state1}, exp1);
            else passes++;
        end
    endtask

    task automatic test_lock_loss();
        do_por();
        repeat (30) tick();
        lock_i = 1'b0;
        for (int e = 31; e <= 53; e++) begin
            tick();
            exp_v = (e <= 32) ? 7'b0011_0_10 : (e <= 35) ? 7'b0000_0_00 :
                    (e <= 51) ? 7'b0000_0_01 : 7'b0001_0_10;
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== exp_v) $display("FAIL lock_loss e%0d: got %b expected %b", e, obs_v, exp_v);
            else passes++;
`ifdef RESET_SEQ_CAUSE_EN
            if (e == 33) begin
                checks++;
                if ({cause, rcnt} !== {2'b01, 8'd1}) $display("FAIL lock_cause: got %b expected %b", {cause, rcnt}, {2'b01, 8'd1});
                else passes++;
            end
`endif
            if (e == 33) lock_i = 1'b1;
        end
    endtask

    task automatic test_sw_rst_done();
        do_por();
        repeat (43) tick();
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        obs_v = {rst_out_n, all_done, state};
        checks++;
        if (obs_v !== 7'b0000_0_00) $display("FAIL sw_done: got %b expected %b", obs_v, 7'b0000_0_00);
        else passes++;
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if ({cause, rcnt} !== {2'b10, 8'd1}) $display("FAIL sw_cause: got %b expected %b", {cause, rcnt}, {2'b10, 8'd1});
        else passes++;
`endif
        for (int e = 45; e <= 61; e++) begin
            tick();
            exp_v = (e >= 61) ? 7'b0001_0_10 : 7'b0000_0_01;
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== exp_v) $display("FAIL sw_restart e%0d: got %b expected %b", e, obs_v, exp_v);
            else passes++;
        end
    endtask

    task automatic test_sw_rst_assert();
        lock_i = 1'b0;
        do_por();
        repeat (4) tick();
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== 7'b0000_0_00) $display("FAIL sw_in_assert k%0d: got %b expected %b", k, obs_v, 7'b0000_0_00);
            else passes++;
`ifdef RESET_SEQ_CAUSE_EN
            checks++;
            if (rcnt !== 8'd0) $display("FAIL sw_assert_cnt: got %0d expected 0", rcnt);
            else passes++;
`endif
            tick();
        end
        lock_i = 1'b1;
    endtask

    task automatic test_async_rst();
        do_por();
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        obs_v = {rst_out_n, all_done, state};
        checks++;
        if (obs_v !== 7'b0000_0_00) $display("FAIL async_rst: got %b expected %b", obs_v, 7'b0000_0_00);
        else passes++;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_v = por_exp(e);
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== exp_v) $display("FAIL async_restart e%0d: got %b expected %b", e, obs_v, exp_v);
            else passes++;
        end
    endtask

    task automatic test_held_sw();
        do_por();
        sw_rst_i = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_v = (e >= 3 && (e % 2) == 1) ? 7'b0000_0_01 : 7'b0000_0_00;
            obs_v = {rst_out_n, all_done, state};
            checks++;
            if (obs_v !== exp_v) $display("FAIL held_sw e%0d: got %b expected %b", e, obs_v, exp_v);
            else passes++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if ({cause, rcnt} !== {2'b10, 8'd4}) $display("FAIL held_sw_cnt: got %b expected %b", {cause, rcnt}, {2'b10, 8'd4});
        else passes++;
`endif
        sw_rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_lock_loss();
        test_sw_rst_done();
        test_sw_rst_assert();
        test_async_rst();
        test_held_sw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
